// File: rtl/pspin_her_pkg.sv
// Shared types and helpers for the HER generator: ctx_id width, tag field layout, skid states.
// Combinational helpers only; no latency, no flow control.
// Build option PSPIN_HER_GEN_STATS_EN is consumed by pspin_her_gen_pipe.
package pspin_her_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    function automatic int ctx_id_width(input int num_ctx);
        return (num_ctx > 1) ? $clog2(num_ctx) : 1;
    endfunction

    // Tag layout from LSB upwards: ctx_id, is_eom, msgid.
    function automatic int tag_eom_lsb(input int num_ctx);
        return ctx_id_width(num_ctx);
    endfunction

    function automatic int tag_msgid_lsb(input int num_ctx);
        return ctx_id_width(num_ctx) + 1;
    endfunction

    function automatic int tag_bits(input int msgid_w, input int num_ctx);
        return msgid_w + 1 + ctx_id_width(num_ctx);
    endfunction

endpackage

// File: rtl/pspin_her_skid.sv
// Output register plus one-entry skid buffer; data appears one cycle after an accept.
// Latency 1 cycle; in_rdy_o is registered and drops once the skid entry will be occupied.
// Upstream must only assert in_vld_i while in_rdy_o is high.
module pspin_her_skid
    import pspin_her_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_vld_i,
    input  logic [W-1:0] in_dat_i,
    input  logic         allow_i,
    output logic         in_rdy_o,
    output logic         out_vld_o,
    output logic [W-1:0] out_dat_o,
    input  logic         out_rdy_i
);

    skid_state_e  state_q;
    logic [W-1:0] out_q;
    logic [W-1:0] skid_q;
    logic         rdy_q;
    logic         full_d;

    // Skid will hold an entry after this edge: ready must already be low next cycle.
    assign full_d = !out_rdy_i && ((state_q == TWO) || (state_q == ONE && in_vld_i));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            rdy_q <= allow_i && !full_d;
            case (state_q)
                EMPTY: begin
                    if (in_vld_i) begin
                        out_q   <= in_dat_i;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (in_vld_i && out_rdy_i) begin
                        out_q <= in_dat_i;
                    end else if (in_vld_i) begin
                        skid_q  <= in_dat_i;
                        state_q <= TWO;
                    end else if (out_rdy_i) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_rdy_i) begin
                        out_q   <= skid_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign in_rdy_o  = rdy_q;
    assign out_vld_o = (state_q != EMPTY);
    assign out_dat_o = out_q;

endmodule

// File: rtl/pspin_her_gen_pipe.sv
// Turns DMA completions into HERs with per-context metadata; optional counters via PSPIN_HER_GEN_STATS_EN.
// Latency 1 cycle gen accept -> her_valid; output register + 1-entry skid, gen_ready registered.
// Backpressure: gen_ready drops while the skid is occupied or context 0 is disabled.
module pspin_her_gen_pipe
    import pspin_her_pkg::*;
#(
    parameter int C_MSGID_WIDTH  = 10,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int LEN_WIDTH      = 20,
    parameter int TAG_WIDTH      = 32,
    parameter int NUM_CTX        = 8,
    parameter int META_WIDTH     = 640,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [NUM_CTX*META_WIDTH-1:0]        conf_meta,
    input  logic [NUM_CTX-1:0]                   conf_ctx_enabled,
    input  logic                                 conf_valid,
    input  logic [AXI_ADDR_WIDTH-1:0]            gen_addr,
    input  logic [LEN_WIDTH-1:0]                 gen_len,
    input  logic [TAG_WIDTH-1:0]                 gen_tag,
    input  logic                                 gen_valid,
    output logic                                 gen_ready,
    output logic                                 her_valid,
    input  logic                                 her_ready,
    output logic [C_MSGID_WIDTH-1:0]             her_msgid,
    output logic                                 her_is_eom,
    output logic [AXI_ADDR_WIDTH-1:0]            her_addr,
    output logic [AXI_ADDR_WIDTH-1:0]            her_size,
    output logic [AXI_ADDR_WIDTH-1:0]            her_xfer_size,
    output logic [META_WIDTH-1:0]                her_meta,
    output logic [ctx_id_width(NUM_CTX)-1:0]     her_ctx_id,
    output logic [NUM_CTX*CNT_WIDTH-1:0]         stat_her_cnt,
    output logic [CNT_WIDTH-1:0]                 stat_fallback_cnt
);

    localparam int CTX_W    = ctx_id_width(NUM_CTX);
    localparam int TAG_BITS = tag_bits(C_MSGID_WIDTH, NUM_CTX);
    localparam int PAY_W    = C_MSGID_WIDTH + 1 + 2*AXI_ADDR_WIDTH + META_WIDTH + CTX_W;

    if (TAG_BITS > TAG_WIDTH) begin : g_tag_too_narrow
        $error("pspin_her_gen_pipe: tag fields need %0d bits, TAG_WIDTH is %0d", TAG_BITS, TAG_WIDTH);
    end

    if (TAG_BITS < TAG_WIDTH) begin : g_tag_hi
        logic unused_tag_hi;
        assign unused_tag_hi = ^gen_tag[TAG_WIDTH-1:TAG_BITS];
    end

    logic [NUM_CTX-1:0][META_WIDTH-1:0] meta_q;
    logic [NUM_CTX-1:0]                 en_q;
    logic [NUM_CTX-1:0]                 en_d;

    assign en_d = conf_valid ? conf_ctx_enabled : en_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= '0;
            en_q   <= '0;
        end else begin
            en_q <= en_d;
            if (conf_valid) begin
                meta_q <= conf_meta;
            end
        end
    end

    logic [CTX_W-1:0]         tag_ctx;
    logic [CTX_W-1:0]         eff_ctx;
    logic                     tag_eom;
    logic [C_MSGID_WIDTH-1:0] tag_msgid;
    logic                     ctx_ok;
    logic                     accept;
    logic [PAY_W-1:0]         pay_in;
    logic [PAY_W-1:0]         pay_out;

    assign tag_ctx   = gen_tag[CTX_W-1:0];
    assign tag_eom   = gen_tag[tag_eom_lsb(NUM_CTX)];
    assign tag_msgid = gen_tag[tag_msgid_lsb(NUM_CTX) +: C_MSGID_WIDTH];
    assign ctx_ok    = en_q[tag_ctx];
    assign eff_ctx   = ctx_ok ? tag_ctx : '0;
    assign accept    = gen_valid && gen_ready;

    // Metadata is sampled from the store at the accept edge, so a same-cycle reconfigure only affects later HERs.
    assign pay_in = {tag_msgid, tag_eom, gen_addr, AXI_ADDR_WIDTH'(gen_len), meta_q[eff_ctx], eff_ctx};

    pspin_her_skid #(
        .W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .in_vld_i  (accept),
        .in_dat_i  (pay_in),
        .allow_i   (en_d[0]),
        .in_rdy_o  (gen_ready),
        .out_vld_o (her_valid),
        .out_dat_o (pay_out),
        .out_rdy_i (her_ready)
    );

    assign {her_msgid, her_is_eom, her_addr, her_size, her_meta, her_ctx_id} = pay_out;
    assign her_xfer_size = her_size;

`ifdef PSPIN_HER_GEN_STATS_EN
    logic [NUM_CTX-1:0][CNT_WIDTH-1:0] her_cnt_q;
    logic [CNT_WIDTH-1:0]              fb_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            her_cnt_q <= '0;
            fb_cnt_q  <= '0;
        end else begin
            if (her_valid && her_ready) begin
                her_cnt_q[her_ctx_id] <= her_cnt_q[her_ctx_id] + CNT_WIDTH'(1);
            end
            if (accept && !ctx_ok) begin
                fb_cnt_q <= fb_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign stat_her_cnt      = her_cnt_q;
    assign stat_fallback_cnt = fb_cnt_q;
`else
    assign stat_her_cnt      = '0;
    assign stat_fallback_cnt = '0;
`endif

endmodule
